// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone register-file slave.
package wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } wb_state_e;

  // Response encoding for the single RESP cycle.
  localparam logic [1:0] RspNone = 2'd0;
  localparam logic [1:0] RspAck  = 2'd1;
  localparam logic [1:0] RspErr  = 2'd2;

  function automatic int unsigned sel_w(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/wb_regfile_slave_if.sv
// Wishbone classic-cycle bus bundle between a master and the register-file slave.
interface wb_regfile_slave_if #(
  parameter int unsigned DW = 32
);

  logic              cyc;
  logic              stb;
  logic              we;
  logic [DW/8-1:0]   sel;
  logic [31:0]       adr;
  logic [DW-1:0]     dat_w;
  logic [DW-1:0]     dat_r;
  logic              ack;
  logic              err;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wb_addr_decode.sv
// Combinational address decode: register index, range hit, read-only hit and error request.
module wb_addr_decode
  import wb_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned NREGS     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [NREGS-1:0] RO_MASK = '0,
  localparam int unsigned IW       = $clog2(NREGS),
  localparam int unsigned SEL_W    = sel_w(DW)
) (
  input  logic [31:0]      adr,
  input  logic             we,
  input  logic [SEL_W-1:0] sel,
  output logic [IW-1:0]    idx,
  output logic             hit,
  output logic             ro_hit,
  output logic             err_req
);

  localparam int unsigned ADDR_LSB = addr_lsb(DW);
  localparam logic [31:0] SPAN     = 32'(NREGS * SEL_W);

  logic [31:0] offset;
  logic [31:0] word;

  always_comb begin
    // Addresses below the base wrap to a large offset and fall out of range.
    offset  = adr - BASE_ADDR;
    word    = offset >> ADDR_LSB;
    idx     = word[IW-1:0];
    hit     = (offset < SPAN) && ((offset % 32'(SEL_W)) == 32'd0);
    ro_hit  = hit && RO_MASK[idx];
    err_req = !hit || (we && (ro_hit || (sel == '0)));
  end

endmodule

// File: rtl/wb_regfile_slave.sv
// Wishbone classic slave exposing a bank of byte-writable registers with RO status slots.
module wb_regfile_slave
  import wb_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned NREGS       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [NREGS-1:0] RO_MASK = '0,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_regfile_slave_if.slave   wbs,
  input  logic [NREGS*DW-1:0] ro_d_i,
  output logic [NREGS*DW-1:0] reg_q_o,
  output logic [NREGS-1:0]    wr_strobe_o
);

  localparam int unsigned SEL_W = sel_w(DW);
  localparam int unsigned IW    = $clog2(NREGS);

  wb_state_e        state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      adr_q, adr_d;
  logic             we_q, we_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [DW-1:0]    dat_q, dat_d;

  logic [DW-1:0]    regs_q [NREGS];
  logic [DW-1:0]    ro_arr [NREGS];

  logic [IW-1:0]    idx;
  logic             hit;
  logic             ro_hit;
  logic             err_req;
  logic [1:0]       rsp;
  logic             wr_en;

  // Decode runs on the latched request so it is stable through WAIT and RESP.
  wb_addr_decode #(
    .DW        (DW),
    .NREGS     (NREGS),
    .BASE_ADDR (BASE_ADDR),
    .RO_MASK   (RO_MASK)
  ) u_decode (
    .adr     (adr_q),
    .we      (we_q),
    .sel     (sel_q),
    .idx     (idx),
    .hit     (hit),
    .ro_hit  (ro_hit),
    .err_req (err_req)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    unique case (state_q)
      StIdle: begin
        if (wbs.cyc && wbs.stb) begin
          adr_d = wbs.adr;
          we_d  = wbs.we;
          sel_d = wbs.sel;
          dat_d = wbs.dat_w;
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES) - 4'd1;
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        if (!wbs.cyc) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
    end
  end

  assign wr_en = (state_q == StResp) && we_q && !err_req;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (sel_q[b]) begin
          regs_q[idx][8*b +: 8] <= dat_q[8*b +: 8];
        end
      end
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_slots
    assign ro_arr[i]             = ro_d_i[i*DW +: DW];
    assign reg_q_o[i*DW +: DW]   = RO_MASK[i] ? '0 : regs_q[i];
  end

  always_comb begin
    rsp = RspNone;
    if (state_q == StResp) begin
      rsp = err_req ? RspErr : RspAck;
    end
  end

  always_comb begin
    wbs.ack     = (rsp == RspAck);
    wbs.err     = (rsp == RspErr);
    wbs.dat_r   = '0;
    wr_strobe_o = '0;
    if ((rsp == RspAck) && !we_q && hit) begin
      wbs.dat_r = ro_hit ? ro_arr[idx] : regs_q[idx];
    end
    if (wr_en) begin
      wr_strobe_o[idx] = 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_regfile_slave.sv
// Scoreboard bench: unit A (no wait states, reg 3 read-only) and unit B (3 wait states).
module tb_wb_regfile_slave;

  localparam logic [31:0] BASE = 32'h3000_0000;

  typedef struct {
    bit          err;
    logic [31:0] dat;
    int          lat;
    logic [15:0] strobe;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  wb_regfile_slave_if #(.DW(32)) bus_a ();
  wb_regfile_slave_if #(.DW(32)) bus_b ();

  logic [511:0] ro_a, ro_b, regq_a, regq_b;
  logic [15:0]  strb_a, strb_b;

  wb_regfile_slave #(
    .DW(32), .NREGS(16), .BASE_ADDR(BASE), .RO_MASK(16'h0008), .WAIT_CYCLES(0)
  ) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst_a), .wbs(bus_a),
    .ro_d_i(ro_a), .reg_q_o(regq_a), .wr_strobe_o(strb_a)
  );

  wb_regfile_slave #(
    .DW(32), .NREGS(16), .BASE_ADDR(BASE), .RO_MASK(16'h0000), .WAIT_CYCLES(3)
  ) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst_b), .wbs(bus_b),
    .ro_d_i(ro_b), .reg_q_o(regq_b), .wr_strobe_o(strb_b)
  );

  int checks = 0;
  int errors = 0;
  int cur = 0;
  exp_t sb[$];
  logic [31:0] model_a [16];
  logic [31:0] model_b [16];

  logic         obs_ack, obs_err;
  logic [31:0]  obs_dat;
  logic [511:0] obs_regq;
  logic [15:0]  obs_strb;

  always_comb begin
    if (cur == 0) begin
      obs_ack = bus_a.ack; obs_err = bus_a.err; obs_dat = bus_a.dat_r;
      obs_regq = regq_a; obs_strb = strb_a;
    end else begin
      obs_ack = bus_b.ack; obs_err = bus_b.err; obs_dat = bus_b.dat_r;
      obs_regq = regq_b; obs_strb = strb_b;
    end
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] exp_regq(input int unit);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) begin
      if (unit == 0) v[i*32 +: 32] = (i == 3) ? 32'h0 : model_a[i];
      else           v[i*32 +: 32] = model_b[i];
    end
    return v;
  endfunction

  task automatic drive(input bit c, input bit w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    if (cur == 0) begin
      bus_a.cyc = c; bus_a.stb = c; bus_a.we = w; bus_a.adr = a; bus_a.sel = s; bus_a.dat_w = d;
    end else begin
      bus_b.cyc = c; bus_b.stb = c; bus_b.we = w; bus_b.adr = a; bus_b.sel = s; bus_b.dat_w = d;
    end
  endtask

  // Push the expected response from the bench model, run the transfer, then pop and compare.
  task automatic xfer(input int unit, input bit w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d);
    exp_t e;
    logic [31:0] off;
    int id;
    bit valid, ro;
    int n;
    logic [31:0] m;
    cur   = unit;
    off   = a - BASE;
    valid = (off < 32'd64) && (off[1:0] == 2'b00);
    id    = int'(off[5:2]);
    ro    = (unit == 0) && (id == 3);
    e.err = !valid || (w && (ro || (s == 4'h0)));
    e.lat = (unit == 0) ? 1 : 4;
    e.strobe = '0;
    e.dat = 32'h0;
    m = (unit == 0) ? model_a[id] : model_b[id];
    if (!e.err && !w) e.dat = ro ? ro_a[3*32 +: 32] : m;
    if (!e.err && w) begin
      for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
      if (unit == 0) model_a[id] = m; else model_b[id] = m;
      e.strobe[id] = 1'b1;
    end
    sb.push_back(e);

    @(posedge clk); #1;
    drive(1'b1, w, a, s, d);
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (obs_ack || obs_err) break;
    end
    e = sb.pop_front();
    if (n >= 20) check("timeout", 1, 0);
    check("lat", n, e.lat);
    check("err", obs_err, e.err);
    check("ack", obs_ack, !e.err);
    check("dat", obs_dat, e.dat);
    check("strobe", obs_strb, e.strobe);
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
    check("no_repeat", {obs_ack, obs_err}, 2'b00);
    check("regq", obs_regq, exp_regq(unit));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      model_a[i] = '0;
      model_b[i] = '0;
      ro_a[i*32 +: 32] = 32'h5100_0000 + 32'(i);
      ro_b[i*32 +: 32] = 32'h0;
    end
    ro_a[3*32 +: 32] = 32'hCAFE_F00D;
    cur = 0; drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    cur = 1; drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      cur = u; #1;
      check("rst_ack", obs_ack, 1'b0);
      check("rst_err", obs_err, 1'b0);
      check("rst_dat", obs_dat, 32'h0);
      check("rst_regq", obs_regq, 512'h0);
      check("rst_strobe", obs_strb, 16'h0);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Unit A: full/partial writes, decode errors, RO slot.
    xfer(0, 1, BASE + 32'h4, 4'hF, 32'hDEAD_BEEF);
    xfer(0, 0, BASE + 32'h4, 4'h0, 32'h0);
    xfer(0, 1, BASE + 32'h4, 4'b0101, 32'h1122_3344);
    xfer(0, 0, BASE + 32'h4, 4'hF, 32'h0);
    check("partial_model", model_a[1], 32'hDE22_BE44);
    xfer(0, 0, BASE + 32'd64, 4'hF, 32'h0);
    xfer(0, 0, BASE + 32'h2, 4'hF, 32'h0);
    xfer(0, 1, BASE - 32'h4, 4'hF, 32'h1234_5678);
    xfer(0, 1, BASE + 32'h8, 4'h0, 32'h1234_5678);
    xfer(0, 0, BASE + 32'hC, 4'hF, 32'h0);
    xfer(0, 1, BASE + 32'hC, 4'hF, 32'h0BAD_0BAD);
    xfer(0, 0, BASE + 32'hC, 4'h0, 32'h0);
    xfer(0, 1, BASE + 32'd60, 4'b1000, 32'hAB00_0000);
    for (int k = 0; k < 8; k++) begin
      xfer(0, 1, BASE + 32'($urandom_range(0, 15) * 4), 4'($urandom_range(0, 15)), $urandom);
      xfer(0, 0, BASE + 32'($urandom_range(0, 15) * 4), 4'hF, 32'h0);
    end

    // Unit B: wait-state latency.
    xfer(1, 1, BASE + 32'h8, 4'hF, 32'hA5A5_1234);
    xfer(1, 0, BASE + 32'h8, 4'hF, 32'h0);
    xfer(1, 0, BASE + 32'h41, 4'hF, 32'h0);

    // Abort: drop cyc during the second WAIT cycle.
    begin
      bit seen;
      cur = 1;
      @(posedge clk); #1;
      drive(1'b1, 1'b1, BASE + 32'h14, 4'hF, 32'h7777_7777);
      @(posedge clk); #1;
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      seen = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (obs_ack || obs_err || (obs_strb != 16'h0)) seen = 1;
      end
      check("abort_resp", seen, 1'b0);
      check("abort_regq", obs_regq, exp_regq(1));
    end
    xfer(1, 0, BASE + 32'h14, 4'hF, 32'h0);

    // Reset asserted mid-transfer during WAIT.
    cur = 1;
    @(posedge clk); #1;
    drive(1'b1, 1'b1, BASE + 32'h8, 4'hF, 32'h0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    #1;
    check("midrst_ack", obs_ack, 1'b0);
    check("midrst_err", obs_err, 1'b0);
    check("midrst_dat", obs_dat, 32'h0);
    check("midrst_regq", obs_regq, 512'h0);
    for (int i = 0; i < 16; i++) model_b[i] = '0;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
    rst_b = 1'b0;
    begin
      bit seen;
      seen = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (obs_ack || obs_err) seen = 1;
      end
      check("midrst_noack", seen, 1'b0);
    end
    xfer(1, 1, BASE + 32'h0, 4'hF, 32'h0F0F_0F0F);
    xfer(1, 0, BASE + 32'h0, 4'hF, 32'h0);
    check("unit_a_untouched", regq_a, exp_regq(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
